// File: rtl/clk_div_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_ctrl_if
// Description : Wishbone slave bus bundle for the clock-divider controller.
//               master modport = bus initiator, slave modport = clk_div_ctrl.
//               Signals: WBs_ADR[16:0], WBs_CYC, WBs_STB, WBs_WE,
//               WBs_BYTE_STB[3:0], WBs_WR_DAT[31:0] (initiator -> slave);
//               WBs_RD_DAT[31:0], WBs_ACK (slave -> initiator).
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_div_ctrl_if;
    logic [16:0] WBs_ADR;
    logic        WBs_CYC;
    logic        WBs_STB;
    logic        WBs_WE;
    logic [3:0]  WBs_BYTE_STB;
    logic [31:0] WBs_WR_DAT;
    logic [31:0] WBs_RD_DAT;
    logic        WBs_ACK;

    modport master (
        output WBs_ADR, WBs_CYC, WBs_STB, WBs_WE, WBs_BYTE_STB, WBs_WR_DAT,
        input  WBs_RD_DAT, WBs_ACK
    );

    modport slave (
        input  WBs_ADR, WBs_CYC, WBs_STB, WBs_WE, WBs_BYTE_STB, WBs_WR_DAT,
        output WBs_RD_DAT, WBs_ACK
    );
endinterface
`default_nettype wire

// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_ctrl
// Description : Wishbone-programmable bank of NUM_CH independent clock
//               dividers producing registered 50%-duty square waves.
// Ports       : WB_CLK      - sole clock, all state on its rising edge
//               WB_RST_n    - asynchronous active-low reset
//               wb          - Wishbone slave bus (clk_div_ctrl_if.slave)
//               clk_div_o   - divided clock outputs, one per channel
//               running_o   - per-channel "not IDLE" flag
// Registers   : word 0 CTRL (EN[3:0]), words 1..4 DIV0..DIV3 ([15:0]),
//               word 5 STATUS (RO, running_o), words 6..7 read as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_ctrl #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 16
) (
    input  wire logic          WB_CLK,
    input  wire logic          WB_RST_n,
    clk_div_ctrl_if.slave      wb,
    output logic [NUM_CH-1:0]  clk_div_o,
    output logic [NUM_CH-1:0]  running_o
);

    localparam logic [2:0] c_IDX_CTRL   = 3'd0;
    localparam logic [2:0] c_IDX_STATUS = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Bus slave
    // ------------------------------------------------------------------
    logic              ack_q;
    logic [31:0]       rd_dat_q;
    logic [NUM_CH-1:0] ctrl_q, ctrl_d;
    logic [DIV_W-1:0]  div_q [NUM_CH];
    logic [DIV_W-1:0]  div_d [NUM_CH];
    logic [2:0]        w_idx;
    logic              w_start;
    logic [31:0]       w_rd_word;

    // Only ADR[4:2] is decoded; the upper data lane and upper byte
    // enables have no register behind them.
    wire unused_bits = &{1'b0, wb.WBs_ADR[16:5], wb.WBs_ADR[1:0],
                         wb.WBs_BYTE_STB[3:2], wb.WBs_WR_DAT[31:DIV_W]};

    assign w_idx   = wb.WBs_ADR[4:2];
    // Gating with ack_q makes a held strobe produce an ack every other cycle.
    assign w_start = wb.WBs_CYC & wb.WBs_STB & ~ack_q;

    assign wb.WBs_ACK    = ack_q;
    assign wb.WBs_RD_DAT = rd_dat_q;

    always_comb begin
        w_rd_word = '0;
        if (w_idx == c_IDX_CTRL)
            w_rd_word[NUM_CH-1:0] = ctrl_q;
        if (w_idx == c_IDX_STATUS)
            w_rd_word[NUM_CH-1:0] = running_o;
        for (int n = 0; n < NUM_CH; n++) begin
            if (w_idx == 3'(n + 1))
                w_rd_word[DIV_W-1:0] = div_q[n];
        end
    end

    always_comb begin
        ctrl_d = ctrl_q;
        for (int n = 0; n < NUM_CH; n++)
            div_d[n] = div_q[n];
        if (w_start && wb.WBs_WE) begin
            if (w_idx == c_IDX_CTRL && wb.WBs_BYTE_STB[0])
                ctrl_d = wb.WBs_WR_DAT[NUM_CH-1:0];
            for (int n = 0; n < NUM_CH; n++) begin
                if (w_idx == 3'(n + 1)) begin
                    for (int k = 0; k < DIV_W / 8; k++) begin
                        if (wb.WBs_BYTE_STB[k])
                            div_d[n][8*k +: 8] = wb.WBs_WR_DAT[8*k +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
        if (!WB_RST_n) begin
            ack_q    <= 1'b0;
            rd_dat_q <= '0;
            ctrl_q   <= '0;
            for (int n = 0; n < NUM_CH; n++)
                div_q[n] <= '0;
        end else begin
            ack_q    <= w_start;
            // Read data is held only alongside the ack, zero otherwise.
            rd_dat_q <= (w_start && !wb.WBs_WE) ? w_rd_word : 32'h0;
            ctrl_q   <= ctrl_d;
            for (int n = 0; n < NUM_CH; n++)
                div_q[n] <= div_d[n];
        end
    end

    // ------------------------------------------------------------------
    // Divider channels
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t           state_q, state_d;
        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic [DIV_W-1:0] act_q, act_d;
        logic             out_q, out_d;
        logic             w_tc;

        assign w_tc = (cnt_q == act_q);

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            act_d   = act_q;
            out_d   = out_q;
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    out_d = 1'b0;
                    if (ctrl_q[g]) begin
                        state_d = S_RUN;
                        act_d   = div_q[g];
                    end
                end
                S_RUN, S_STOP: begin
                    if (!ctrl_q[g] && !out_q) begin
                        // Disabled while low: stop at once, no pulse is cut.
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        // The divide value is sampled only at terminal
                        // count, so a phase already in progress is never
                        // shortened or stretched by a DIV write.
                        if (w_tc) begin
                            cnt_d = '0;
                            act_d = div_q[g];
                            out_d = ~out_q;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        // Disabled while high: finish the high phase, then
                        // drop to IDLE together with the falling edge.
                        if (ctrl_q[g])
                            state_d = S_RUN;
                        else if (w_tc)
                            state_d = S_IDLE;
                        else
                            state_d = S_STOP;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    out_d   = 1'b0;
                end
            endcase
        end

        always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
            if (!WB_RST_n) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                act_q   <= '0;
                out_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                act_q   <= act_d;
                out_q   <= out_d;
            end
        end

        assign clk_div_o[g] = out_q;
        assign running_o[g] = (state_q != S_IDLE);
    end

endmodule
`default_nettype wire

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter: NUM_CH, 4, number of divider channels (fixed 4 for this release).
REQ-002 Parameter: DIV_W, 16, divide-register width in bits.
REQ-003 Port: WB_CLK  input  1  sole clock; all state on its rising edge.
REQ-004 Port: WB_RST_n  input  1  one clock; reset is asynchronous and active-low.
REQ-005 Port: WBs_ADR  input  17  Wishbone byte address; only bits [4:2] decoded, others ignored.
REQ-006 Port: WBs_CYC  input  1  cycle/chip select.
REQ-007 Port: WBs_STB  input  1  transfer strobe.
REQ-008 Port: WBs_WE  input  1  1 = write, 0 = read.
REQ-009 Port: WBs_BYTE_STB  input  4  byte enables for writes.
REQ-010 Port: WBs_WR_DAT  input  32  write data.
REQ-011 Port: WBs_RD_DAT  output  32  read data, valid while WBs_ACK = 1.
REQ-012 Port: WBs_ACK  output  1  single-cycle transfer acknowledge.
REQ-013 Port: clk_div_o  output  NUM_CH  divided square-wave outputs, registered, intended for gclkbuff inputs.
REQ-014 Port: running_o  output  NUM_CH  per-channel "not IDLE" flag.

Function
REQ-015 Register map (word index = WBs_ADR[4:2]): 0 CTRL (R/W, bits[3:0] = EN[3:0]); 1..4 DIV0..DIV3 (R/W, bits[15:0]); 5 STATUS (RO, bits[3:0] = running_o); 6,7 unmapped.
REQ-016 Transfer starts when WBs_CYC & WBs_STB & ~WBs_ACK; WBs_ACK asserts the following cycle for exactly one cycle; write commits on the start cycle.
REQ-017 Back-to-back: WBs_ACK never high two consecutive cycles; a held strobe is acked every second cycle.
REQ-018 Byte enables: CTRL updated only if BYTE_STB[0]; DIVn byte k (k=0,1) updated only if BYTE_STB[k]; STATUS/unmapped writes ignored but acked.
REQ-019 Reads: unused bits and unmapped words return 0; WBs_RD_DAT = 0 when WBs_ACK = 0.
REQ-020 Per-channel FSM states IDLE, RUN, STOP; counter cnt[DIV_W-1:0], active divide act[DIV_W-1:0].
REQ-021 IDLE: cnt = 0, clk_div_o = 0; EN = 1 -> RUN next cycle with act <= DIVn, cnt = 0.
REQ-022 RUN: cnt increments each cycle; when cnt == act: clk_div_o toggles, cnt <= 0, act <= DIVn (value registered before any same-cycle write).
REQ-023 Output period = 2*(act+1) WB_CLK cycles, 50% duty; DIV = 0 yields WB_CLK/2.
REQ-024 DIVn writes during RUN take effect only at the next terminal count; no truncated high/low phase.
REQ-025 EN cleared in RUN: if clk_div_o = 0 -> IDLE next cycle; else -> STOP.
REQ-026 STOP: counting continues; at terminal count output falls to 0 and state -> IDLE; no pulse shorter than act+1 cycles.
REQ-027 EN set again while in STOP -> RUN, counting uninterrupted, no phase reset.
REQ-028 running_o[n] = 1 in RUN or STOP, registered with the state.
REQ-029 Channels are independent; no cross-channel phase alignment.

Reset
REQ-030 WB_RST_n low asynchronously forces: CTRL = 0, DIVn = 0, all FSMs IDLE, cnt/act = 0, clk_div_o = 0, running_o = 0, WBs_ACK = 0, WBs_RD_DAT = 0.
REQ-031 Reset asserted mid-operation or mid-transfer: transfer aborted, no ACK; outputs go low immediately; release is synchronous to next WB_CLK edge.

Verification
REQ-032 Write DIV0 = 3, CTRL = 0x1 -> clk_div_o[0] period 8 cycles, 4 high/4 low; running_o[0] = 1; read STATUS = 0x1.
REQ-033 DIV1 = 0, EN1 on -> clk_div_o[1] toggles every cycle; write DIV1 = 2 mid-high-phase -> current phase stays 1 cycle, next phases 3 cycles.
REQ-034 Channel 2, DIV2 = 5, clear EN2 one cycle after rising output -> output stays high 6 cycles, falls, running_o[2] = 0 next cycle; no glitch.
REQ-035 Clear then re-set EN3 during STOP -> output continuous, period unchanged, running_o[3] never drops.
REQ-036 Write DIV0 = 0xABCD with BYTE_STB = 0x1 over previous 0x1234 -> readback 0x12CD; read word 6 -> 0 with ACK; held STB -> ACK alternating 1,0,1.
REQ-037 Pulse WB_RST_n low with all channels running and a read pending -> all outputs 0 immediately, no ACK, all registers read 0 after release.
